// File: rtl/wb_pkg.sv
// Shared types for the rv32 writeback stage.
//  load_size_t : width of a load as decoded by execute (2'b11 is treated as a full word)
//  wb_state_t  : writeback FSM state
package wb_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } load_size_t;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data lane extraction and sign/zero extension.
// Shared with the forwarding unit, so it holds no state.
//  rdata       in   XLEN  word-aligned data from data memory
//  size        in   2     load width (load_size_t)
//  is_unsigned in   1     1 = zero-extend, 0 = sign-extend
//  addr_lo     in   2     load byte address [1:0]
//  value       out  XLEN  extracted, extended result
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  load_size_t      size,
    input  logic            is_unsigned,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        unique case (addr_lo)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase

        // addr_lo[0] is ignored for halfwords; misalignment is trapped upstream.
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            LS_BYTE: value = {{(XLEN-8){~is_unsigned & byte_lane[7]}}, byte_lane};
            LS_HALF: value = {{(XLEN-16){~is_unsigned & half_lane[15]}}, half_lane};
            // LS_WORD and the unused 2'b11 encoding both return the full word.
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final rv32 pipeline stage: drives the register-file write port.
// ALU results are written the cycle after acceptance; loads wait for data memory
// (stalling execute via ex_ready) and are aborted after LOAD_TIMEOUT waiting cycles.
//  clk, rst                        clock, asynchronous active-high reset
//  ex_valid/ex_ready               execute handshake (ex_ready = state is IDLE)
//  ex_reg_write, ex_rd, ex_result  destination and ALU result
//  ex_is_load, ex_load_size,
//  ex_load_unsigned, ex_addr_lo    load descriptor
//  mem_rvalid, mem_rdata           load return (single-cycle pulse)
//  register_write_en/rd_address/
//  register_write_data             registered write port
//  load_timeout                    one-cycle pulse on load abort
//  spurious_rvalid                 sticky: mem_rvalid seen outside WAIT_LOAD
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_result,
    input  logic                  ex_is_load,
    input  load_size_t            ex_load_size,
    input  logic                  ex_load_unsigned,
    input  logic [1:0]            ex_addr_lo,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  register_write_en,
    output logic [REG_ADDR_W-1:0] rd_address,
    output logic [XLEN-1:0]       register_write_data,
    output logic                  load_timeout,
    output logic                  spurious_rvalid
);

    localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    wb_state_t             state_q;
    logic [CNT_W-1:0]      timer_q;
    logic                  pend_write_q;  // reg_write already gated with rd != 0
    logic [REG_ADDR_W-1:0] pend_rd_q;
    load_size_t            pend_size_q;
    logic                  pend_unsigned_q;
    logic [1:0]            pend_addr_lo_q;
    logic [XLEN-1:0]       load_value;

    assign ex_ready = (state_q == WB_IDLE);

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .rdata      (mem_rdata),
        .size       (pend_size_q),
        .is_unsigned(pend_unsigned_q),
        .addr_lo    (pend_addr_lo_q),
        .value      (load_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= WB_IDLE;
            timer_q             <= '0;
            pend_write_q        <= 1'b0;
            pend_rd_q           <= '0;
            pend_size_q         <= LS_BYTE;
            pend_unsigned_q     <= 1'b0;
            pend_addr_lo_q      <= 2'd0;
            register_write_en   <= 1'b0;
            rd_address          <= '0;
            register_write_data <= '0;
            load_timeout        <= 1'b0;
            spurious_rvalid     <= 1'b0;
        end else begin
            register_write_en <= 1'b0;
            load_timeout      <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (mem_rvalid) begin
                        spurious_rvalid <= 1'b1;
                    end
                    if (ex_valid) begin
                        if (ex_is_load) begin
                            pend_write_q    <= ex_reg_write & (ex_rd != '0);
                            pend_rd_q       <= ex_rd;
                            pend_size_q     <= ex_load_size;
                            pend_unsigned_q <= ex_load_unsigned;
                            pend_addr_lo_q  <= ex_addr_lo;
                            timer_q         <= '0;
                            state_q         <= WB_WAIT_LOAD;
                        end else if (ex_reg_write && (ex_rd != '0)) begin
                            // Address/data only move on a real write; they hold otherwise.
                            register_write_en   <= 1'b1;
                            rd_address          <= ex_rd;
                            register_write_data <= ex_result;
                        end
                    end
                end
                WB_WAIT_LOAD: begin
                    // rvalid takes priority over an expiring timer.
                    if (mem_rvalid) begin
                        if (pend_write_q) begin
                            register_write_en   <= 1'b1;
                            rd_address          <= pend_rd_q;
                            register_write_data <= load_value;
                        end
                        state_q <= WB_IDLE;
                    end else if (timer_q == CNT_LAST) begin
                        load_timeout <= 1'b1;
                        state_q      <= WB_IDLE;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int unsigned LOAD_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    load_size_t  ex_load_size;
    logic        ex_load_unsigned;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        register_write_en;
    logic [4:0]  rd_address;
    logic [31:0] register_write_data;
    logic        load_timeout;
    logic        spurious_rvalid;

    writeback_unit #(
        .XLEN(32),
        .REG_ADDR_W(5),
        .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .ex_reg_write       (ex_reg_write),
        .ex_rd              (ex_rd),
        .ex_result          (ex_result),
        .ex_is_load         (ex_is_load),
        .ex_load_size       (ex_load_size),
        .ex_load_unsigned   (ex_load_unsigned),
        .ex_addr_lo         (ex_addr_lo),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata),
        .register_write_en  (register_write_en),
        .rd_address         (rd_address),
        .register_write_data(register_write_data),
        .load_timeout       (load_timeout),
        .spurious_rvalid    (spurious_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  addr_lo;
        logic [31:0] rdata;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[14];
    int          total = 0;
    int          bad = 0;
    logic [4:0]  last_rd = 5'd0;
    logic [31:0] last_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic is_load, input logic reg_write, input logic [4:0] rd,
                            input logic [31:0] result, input logic [1:0] size, input logic uns,
                            input logic [1:0] addr_lo);
        ex_valid         = 1'b1;
        ex_is_load       = is_load;
        ex_reg_write     = reg_write;
        ex_rd            = rd;
        ex_result        = result;
        ex_load_size     = load_size_t'(size);
        ex_load_unsigned = uns;
        ex_addr_lo       = addr_lo;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive_op(v.is_load, v.reg_write, v.rd, v.result, v.size, v.uns, v.addr_lo);
        @(negedge clk);
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        if (v.is_load) begin
            check($sformatf("v%0d ready_wait", idx), 32'(ex_ready), 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        if (v.exp_en) begin
            last_rd   = v.rd;
            last_data = v.exp_data;
        end
        check($sformatf("v%0d en", idx), 32'(register_write_en), 32'(v.exp_en));
        check($sformatf("v%0d rd", idx), 32'(rd_address), 32'(last_rd));
        check($sformatf("v%0d data", idx), register_write_data, last_data);
        check($sformatf("v%0d ready", idx), 32'(ex_ready), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d en_drop", idx), 32'(register_write_en), 32'd0);
    endtask

    initial begin
        //            ld    wr    rd     result         sz    uns   alo   rdata          en    data
        vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b1, 5'd0, 32'h12345678, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd7, 32'h0BADF00D, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 2'd0, 1'b0, 2'd3, 32'h80123456, 1'b1, 32'hFFFFFF80};
        vecs[4]  = '{1'b1, 1'b1, 5'd3, 32'h0,        2'd1, 1'b1, 2'd2, 32'h80123456, 1'b1, 32'h00008012};
        vecs[5]  = '{1'b1, 1'b1, 5'd4, 32'h0,        2'd0, 1'b1, 2'd0, 32'h80123456, 1'b1, 32'h00000056};
        vecs[6]  = '{1'b1, 1'b1, 5'd6, 32'h0,        2'd0, 1'b0, 2'd1, 32'h80123456, 1'b1, 32'h00000034};
        vecs[7]  = '{1'b1, 1'b1, 5'd8, 32'h0,        2'd1, 1'b0, 2'd1, 32'h00008001, 1'b1, 32'hFFFF8001};
        vecs[8]  = '{1'b1, 1'b1, 5'd8, 32'h0,        2'd1, 1'b0, 2'd3, 32'h80123456, 1'b1, 32'hFFFF8012};
        vecs[9]  = '{1'b1, 1'b1, 5'd31, 32'h0,       2'd2, 1'b0, 2'd2, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 1'b1, 5'd30, 32'h0,       2'd3, 1'b0, 2'd1, 32'h12345678, 1'b1, 32'h12345678};
        vecs[11] = '{1'b1, 1'b1, 5'd0, 32'h0,        2'd2, 1'b0, 2'd0, 32'h55555555, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 5'd2, 32'h0,        2'd1, 1'b1, 2'd0, 32'h0000FFFF, 1'b1, 32'h0000FFFF};
        vecs[13] = '{1'b1, 1'b1, 5'd2, 32'h0,        2'd0, 1'b0, 2'd2, 32'h00FF0000, 1'b1, 32'hFFFFFFFF};

        rst = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        drive_op(1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 1'b0, 2'd0);
        ex_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst en", 32'(register_write_en), 32'd0);
        check("rst rd", 32'(rd_address), 32'd0);
        check("rst data", register_write_data, 32'd0);
        check("rst timeout", 32'(load_timeout), 32'd0);
        check("rst spurious", 32'(spurious_rvalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst ready", 32'(ex_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            apply_vec(vecs[i], i);
        end

        // Load stalls a held instruction; both writes land on consecutive cycles.
        @(negedge clk);
        drive_op(1'b1, 1'b1, 5'd10, 32'd0, 2'd0, 1'b0, 2'd3);
        @(negedge clk);
        drive_op(1'b0, 1'b1, 5'd9, 32'h11112222, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold ready_wait%0d", i), 32'(ex_ready), 32'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80123456;
        check("hold ready_rvalid", 32'(ex_ready), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("hold load en", 32'(register_write_en), 32'd1);
        check("hold load rd", 32'(rd_address), 32'd10);
        check("hold load data", register_write_data, 32'hFFFFFF80);
        check("hold ready_after", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("hold alu en", 32'(register_write_en), 32'd1);
        check("hold alu rd", 32'(rd_address), 32'd9);
        check("hold alu data", register_write_data, 32'h11112222);
        last_rd = 5'd9;
        last_data = 32'h11112222;
        @(negedge clk);
        check("hold en_drop", 32'(register_write_en), 32'd0);

        // Timeout: LOAD_TIMEOUT waiting cycles then abort without a write.
        @(negedge clk);
        drive_op(1'b1, 1'b1, 5'd11, 32'd0, 2'd2, 1'b0, 2'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        ex_is_load = 1'b0;
        for (int i = 0; i < int'(LOAD_TIMEOUT); i++) begin
            check($sformatf("to ready_wait%0d", i), 32'(ex_ready), 32'd0);
            check($sformatf("to early%0d", i), 32'(load_timeout), 32'd0);
            @(negedge clk);
        end
        check("to pulse", 32'(load_timeout), 32'd1);
        check("to ready", 32'(ex_ready), 32'd1);
        check("to no_write", 32'(register_write_en), 32'd0);
        check("to data_hold", register_write_data, last_data);
        @(negedge clk);
        check("to pulse_drop", 32'(load_timeout), 32'd0);

        // rvalid on the final waiting cycle beats the timeout.
        @(negedge clk);
        drive_op(1'b1, 1'b1, 5'd12, 32'd0, 2'd2, 1'b0, 2'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        ex_is_load = 1'b0;
        repeat (LOAD_TIMEOUT - 1) @(negedge clk);
        check("race ready_wait", 32'(ex_ready), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A55A5A;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("race en", 32'(register_write_en), 32'd1);
        check("race rd", 32'(rd_address), 32'd12);
        check("race data", register_write_data, 32'hA5A55A5A);
        check("race no_timeout", 32'(load_timeout), 32'd0);
        check("race ready", 32'(ex_ready), 32'd1);

        // Reset mid-load, then a stray rvalid.
        @(negedge clk);
        check("spur clear", 32'(spurious_rvalid), 32'd0);
        drive_op(1'b1, 1'b1, 5'd13, 32'd0, 2'd2, 1'b0, 2'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        ex_is_load = 1'b0;
        check("mid ready_wait", 32'(ex_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid rst en", 32'(register_write_en), 32'd0);
        check("mid rst rd", 32'(rd_address), 32'd0);
        check("mid rst data", register_write_data, 32'd0);
        check("mid rst ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77777777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("mid no_write", 32'(register_write_en), 32'd0);
        check("mid data", register_write_data, 32'd0);
        check("mid spurious", 32'(spurious_rvalid), 32'd1);
        @(negedge clk);
        check("mid spurious_sticky", 32'(spurious_rvalid), 32'd1);
        check("mid en_idle", 32'(register_write_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
